// File: rtl/serv_wb_arbiter_pkg.sv
// Shared types for the three-way Wishbone arbiter: grant and state encodings,
// plus the timeout counter width helper.
package serv_wb_arbiter_pkg;

  // Which master currently owns the shared port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IBUS = 2'd1,
    GNT_DBUS = 2'd2,
    GNT_EXT  = 2'd3
  } gnt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Byte enables presented for instruction fetches (always full-word reads).
  localparam logic [3:0] IBUS_SEL = 4'b1111;

  // Width needed to count up to the timeout limit; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/serv_wb_arb_timer.sv
// Saturating transaction timer: counts busy cycles without ack and flags when
// the programmed limit is reached. A limit of zero never flags.
module serv_wb_arb_timer
  import serv_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam int unsigned W = cnt_width(TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_cnt;

  // Counter clears while idle and stops at the limit rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_hit = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/serv_wb_arbiter.sv
// Registered three-way Wishbone classic arbiter sharing one memory port between
// the core instruction bus, the core data bus and an external master.
module serv_wb_arbiter
  import serv_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic [31:0] i_ext_adr,
  input  logic [31:0] i_ext_dat,
  input  logic [3:0]  i_ext_sel,
  input  logic        i_ext_we,
  input  logic        i_ext_cyc,
  output logic [31:0] o_ext_rdt,
  output logic        o_ext_ack,
  output logic        o_ext_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout
);

  state_e r_state, w_state_nxt;
  gnt_e   r_grant, w_grant_nxt;
  logic   r_last_ext, w_last_ext_nxt;
  logic   r_timeout, w_timeout_nxt;

  logic   w_busy;
  logic   w_gnt_cyc;
  logic   w_active;
  logic   w_done;
  logic   w_to;
  logic   w_hit;
  logic   w_core_req;
  logic   w_any_req;
  gnt_e   w_core_gnt;
  gnt_e   w_winner;

  assign w_busy = (r_state == ST_BUSY);

  serv_wb_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (!w_busy),
    .i_en  (w_busy && !i_wb_ack),
    .o_hit (w_hit)
  );

  // State register: FSM state, grant, fairness bit and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= GNT_NONE;
      r_last_ext <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last_ext <= w_last_ext_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Round-robin pick between the core (dbus before ibus) and the external master.
  always_comb begin
    w_core_req = i_ibus_cyc | i_dbus_cyc;
    w_core_gnt = i_dbus_cyc ? GNT_DBUS : GNT_IBUS;
    w_any_req  = w_core_req | i_ext_cyc;
    if (w_core_req && i_ext_cyc) begin
      w_winner = r_last_ext ? w_core_gnt : GNT_EXT;
    end else if (i_ext_cyc) begin
      w_winner = GNT_EXT;
    end else begin
      w_winner = w_core_gnt;
    end
  end

  // Shared-port request mux; follows the registered grant only, so it is stable
  // for the whole transaction.
  always_comb begin
    o_wb_adr  = '0;
    o_wb_dat  = '0;
    o_wb_sel  = '0;
    o_wb_we   = 1'b0;
    w_gnt_cyc = 1'b0;
    unique case (r_grant)
      GNT_IBUS: begin
        o_wb_adr  = i_ibus_adr;
        o_wb_sel  = IBUS_SEL;
        w_gnt_cyc = i_ibus_cyc;
      end
      GNT_DBUS: begin
        o_wb_adr  = i_dbus_adr;
        o_wb_dat  = i_dbus_dat;
        o_wb_sel  = i_dbus_sel;
        o_wb_we   = i_dbus_we;
        w_gnt_cyc = i_dbus_cyc;
      end
      GNT_EXT: begin
        o_wb_adr  = i_ext_adr;
        o_wb_dat  = i_ext_dat;
        o_wb_sel  = i_ext_sel;
        o_wb_we   = i_ext_we;
        w_gnt_cyc = i_ext_cyc;
      end
      GNT_NONE: begin
        o_wb_adr = '0;
      end
      default: begin
        o_wb_adr = '0;
      end
    endcase
  end

  // Transaction status; a real ack always beats a coincident timeout.
  always_comb begin
    w_active = w_busy && w_gnt_cyc;
    w_done   = w_active && i_wb_ack;
    w_to     = w_active && w_hit && !i_wb_ack;
  end

  // Next-state: grant on any request in idle, release on ack, timeout or abort.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_ext_nxt = r_last_ext;
    w_timeout_nxt  = r_timeout | w_to;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = ST_BUSY;
          w_grant_nxt    = w_winner;
          w_last_ext_nxt = (w_winner == GNT_EXT);
        end
      end
      ST_BUSY: begin
        if (!w_gnt_cyc || i_wb_ack || w_to) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = GNT_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = GNT_NONE;
      end
    endcase
  end

  // Response routing: only the granted master sees ack/err/rdt.
  always_comb begin
    o_wb_cyc   = w_active;
    o_ibus_ack = (r_grant == GNT_IBUS) && (w_done || w_to);
    o_dbus_ack = (r_grant == GNT_DBUS) && (w_done || w_to);
    o_ext_ack  = (r_grant == GNT_EXT) && w_done;
    o_ext_err  = (r_grant == GNT_EXT) && w_to;
    o_ibus_rdt = ((r_grant == GNT_IBUS) && w_done) ? i_wb_rdt : '0;
    o_dbus_rdt = ((r_grant == GNT_DBUS) && w_done) ? i_wb_rdt : '0;
    o_ext_rdt  = ((r_grant == GNT_EXT) && w_done) ? i_wb_rdt : '0;
  end

  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Self-checking bench for serv_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_serv_wb_arbiter;

  localparam int unsigned TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr, i_dbus_adr, i_dbus_dat, i_ext_adr, i_ext_dat;
  logic        i_ibus_cyc, i_dbus_cyc, i_dbus_we, i_ext_we, i_ext_cyc;
  logic [3:0]  i_dbus_sel, i_ext_sel;
  logic [31:0] o_ibus_rdt, o_dbus_rdt, o_ext_rdt, o_wb_adr, o_wb_dat;
  logic        o_ibus_ack, o_dbus_ack, o_ext_ack, o_ext_err, o_wb_we, o_wb_cyc;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_timeout;

  serv_wb_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk      (i_clk),      .i_rst      (i_rst),
    .i_ibus_adr (i_ibus_adr), .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt), .o_ibus_ack (o_ibus_ack),
    .i_dbus_adr (i_dbus_adr), .i_dbus_dat (i_dbus_dat), .i_dbus_sel (i_dbus_sel),
    .i_dbus_we  (i_dbus_we),  .i_dbus_cyc (i_dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt), .o_dbus_ack (o_dbus_ack),
    .i_ext_adr  (i_ext_adr),  .i_ext_dat  (i_ext_dat),  .i_ext_sel  (i_ext_sel),
    .i_ext_we   (i_ext_we),   .i_ext_cyc  (i_ext_cyc),
    .o_ext_rdt  (o_ext_rdt),  .o_ext_ack  (o_ext_ack),  .o_ext_err  (o_ext_err),
    .o_wb_adr   (o_wb_adr),   .o_wb_dat   (o_wb_dat),   .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (i_wb_rdt),   .i_wb_ack   (i_wb_ack),   .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave ----------------
  bit          slave_rand  = 1'b0;
  int          slave_delay = 0;   // ack on this busy cycle; 0 = never
  logic [31:0] slave_rdt   = '0;

  initial begin
    int age = 0;
    forever begin
      @(posedge i_clk);
      #2;
      if (slave_rand) begin
        i_wb_ack = o_wb_cyc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        i_wb_rdt = $urandom;
      end else begin
        if (o_wb_cyc) age++;
        else age = 0;
        i_wb_ack = o_wb_cyc && (slave_delay != 0) && (age == slave_delay);
        i_wb_rdt = slave_rdt;
      end
    end
  end

  // ---------------- reference model ----------------
  // Owner: 0 none, 1 ibus, 2 dbus, 3 ext. m_age = busy cycles elapsed without ack.
  bit model_on = 1'b0;
  bit m_busy, m_last_ext, m_sticky, m_hit;
  int m_owner, m_age;

  function automatic logic own_cyc(input int o);
    return (o == 1) ? i_ibus_cyc : (o == 2) ? i_dbus_cyc : (o == 3) ? i_ext_cyc : 1'b0;
  endfunction
  function automatic logic [31:0] own_adr(input int o);
    return (o == 1) ? i_ibus_adr : (o == 2) ? i_dbus_adr : (o == 3) ? i_ext_adr : 32'h0;
  endfunction
  function automatic logic [31:0] own_dat(input int o);
    return (o == 2) ? i_dbus_dat : (o == 3) ? i_ext_dat : 32'h0;
  endfunction
  function automatic logic [3:0] own_sel(input int o);
    return (o == 1) ? 4'hf : (o == 2) ? i_dbus_sel : (o == 3) ? i_ext_sel : 4'h0;
  endfunction
  function automatic logic own_we(input int o);
    return (o == 2) ? i_dbus_we : (o == 3) ? i_ext_we : 1'b0;
  endfunction

  initial begin
    logic act, fin;
    logic [6:0] e_ctrl;
    int core;
    forever begin
      @(negedge i_clk);
      if (model_on) begin
        act   = m_busy && own_cyc(m_owner);
        fin   = act && i_wb_ack;
        m_hit = act && (m_age == int'(TO)) && (TO != 0) && !i_wb_ack;
        e_ctrl = {(m_owner == 1) && (fin || m_hit), (m_owner == 2) && (fin || m_hit),
                  (m_owner == 3) && fin, (m_owner == 3) && m_hit, act,
                  own_we(m_owner), m_sticky};
        chk("ctrl{iack,dack,eack,eerr,cyc,we,to}",
            {25'b0, o_ibus_ack, o_dbus_ack, o_ext_ack, o_ext_err, o_wb_cyc, o_wb_we,
             o_timeout}, {25'b0, e_ctrl});
        chk("wb_adr", o_wb_adr, own_adr(m_owner));
        chk("wb_dat", o_wb_dat, own_dat(m_owner));
        chk("wb_sel", {28'b0, o_wb_sel}, {28'b0, own_sel(m_owner)});
        chk("ibus_rdt", o_ibus_rdt, (fin && m_owner == 1) ? i_wb_rdt : 32'h0);
        chk("dbus_rdt", o_dbus_rdt, (fin && m_owner == 2) ? i_wb_rdt : 32'h0);
        chk("ext_rdt", o_ext_rdt, (fin && m_owner == 3) ? i_wb_rdt : 32'h0);
      end
      @(posedge i_clk);
      if (i_rst === 1'b1) begin
        model_on = 1'b1;
        m_busy = 0; m_owner = 0; m_last_ext = 0; m_sticky = 0; m_age = 0; m_hit = 0;
      end else if (model_on) begin
        if (!m_busy) begin
          core = i_dbus_cyc ? 2 : i_ibus_cyc ? 1 : 0;
          if (core != 0 || i_ext_cyc) begin
            if (core != 0 && i_ext_cyc) m_owner = m_last_ext ? core : 3;
            else m_owner = i_ext_cyc ? 3 : core;
            m_last_ext = (m_owner == 3);
            m_busy = 1;
            m_age = 0;
          end
        end else if (!own_cyc(m_owner) || i_wb_ack || m_hit) begin
          if (m_hit) m_sticky = 1;
          m_busy = 0;
          m_owner = 0;
        end else begin
          m_age++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_masters();
    i_ibus_cyc = 0; i_dbus_cyc = 0; i_ext_cyc = 0;
  endtask

  task automatic rst_dut();
    next_cycle();
    i_rst = 1'b1;
    idle_masters();
    next_cycle();
    i_rst = 1'b0;
  endtask

  initial begin
    int cnt, cnt2, k;
    bit drop;
    int seq [8];
    bit seen [3];

    i_rst = 1'b1;
    i_ibus_adr = 0; i_dbus_adr = 0; i_dbus_dat = 0; i_ext_adr = 0; i_ext_dat = 0;
    i_dbus_sel = 0; i_ext_sel = 0; i_dbus_we = 0; i_ext_we = 0;
    idle_masters();
    i_wb_ack = 0; i_wb_rdt = 0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_cyc", {31'b0, o_wb_cyc}, 0);
    chk("rst_acks", {28'b0, o_ibus_ack, o_dbus_ack, o_ext_ack, o_ext_err}, 0);
    chk("rst_adr", o_wb_adr, 0);
    chk("rst_timeout", {31'b0, o_timeout}, 0);

    // ibus fetch, slave acks on third busy cycle
    slave_delay = 3; slave_rdt = 32'h0000_0013;
    cnt = 0; drop = 0;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c == 0) begin i_ibus_adr = 32'h100; i_ibus_cyc = 1; end
      if (drop) begin i_ibus_cyc = 0; drop = 0; end
      @(negedge i_clk);
      if (c == 0) chk("ibus_cyc_c0", {31'b0, o_wb_cyc}, 0);
      if (c == 1) chk("ibus_cyc_c1", {31'b0, o_wb_cyc}, 1);
      if (c == 4) chk("ibus_cyc_after", {31'b0, o_wb_cyc}, 0);
      if (o_ibus_ack) begin
        cnt++; drop = 1;
        chk("ibus_rdt", o_ibus_rdt, 32'h13);
        chk("ibus_ack_cycle", c, 3);
      end
    end
    chk("ibus_ack_count", cnt, 1);

    // ext + dbus contend continuously: EXT, DBUS, EXT, DBUS
    rst_dut();
    slave_delay = 1; slave_rdt = 32'h5555_aaaa;
    i_ext_adr = 32'he000_0000; i_ext_we = 1; i_ext_dat = 32'h1111_2222; i_ext_sel = 4'h3;
    i_dbus_adr = 32'hd000_0010; i_dbus_we = 0; i_dbus_sel = 4'hf;
    i_ext_cyc = 1; i_dbus_cyc = 1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      @(negedge i_clk);
      if ((o_ext_ack || o_dbus_ack) && k < 8) begin
        seq[k] = o_ext_ack ? 3 : 2;
        chk("alt_adr", o_wb_adr, o_ext_ack ? 32'he000_0000 : 32'hd000_0010);
        k++;
      end
    end
    chk("alt_count", {31'b0, (k >= 4)}, 1);
    chk("alt_0", seq[0], 3);
    chk("alt_1", seq[1], 2);
    chk("alt_2", seq[2], 3);
    chk("alt_3", seq[3], 2);

    // dbus read timeout
    rst_dut();
    slave_delay = 0; slave_rdt = 32'hdead_beef;
    i_dbus_we = 0; i_dbus_adr = 32'h40;
    cnt = 0; drop = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      if (c == 0) i_dbus_cyc = 1;
      if (drop) begin i_dbus_cyc = 0; drop = 0; end
      @(negedge i_clk);
      if (c == 4) chk("dto_no_ack_c4", {31'b0, o_dbus_ack}, 0);
      if (c == 5) begin
        chk("dto_ack_c5", {31'b0, o_dbus_ack}, 1);
        chk("dto_rdt", o_dbus_rdt, 0);
      end
      if (c == 6 || c == 9) chk("dto_sticky", {31'b0, o_timeout}, 1);
      if (o_dbus_ack) begin cnt++; drop = 1; end
    end
    chk("dto_ack_count", cnt, 1);

    // ext write timeout -> error, never ack
    rst_dut();
    i_ext_we = 1;
    cnt = 0; cnt2 = 0; drop = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      if (c == 0) i_ext_cyc = 1;
      if (drop) begin i_ext_cyc = 0; drop = 0; end
      @(negedge i_clk);
      if (o_ext_err) begin cnt++; drop = 1; chk("eto_err_cycle", c, 5); end
      if (o_ext_ack) cnt2++;
    end
    chk("eto_err_count", cnt, 1);
    chk("eto_ack_count", cnt2, 0);

    // ack coincides with timeout hit
    rst_dut();
    slave_delay = 5; slave_rdt = 32'h1234_5678;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      if (c == 0) i_ibus_cyc = 1;
      if (c == 6) i_ibus_cyc = 0;
      @(negedge i_clk);
      if (c == 5) begin
        chk("race_ack", {31'b0, o_ibus_ack}, 1);
        chk("race_rdt", o_ibus_rdt, 32'h1234_5678);
      end
      if (c == 7) chk("race_timeout", {31'b0, o_timeout}, 0);
    end

    // reset mid-busy with ext granted; fairness bit must restart
    rst_dut();
    slave_delay = 0;
    i_ibus_adr = 32'h200;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c == 0) i_ext_cyc = 1;
      if (c == 2) i_rst = 1;
      if (c == 3) begin i_rst = 0; i_ibus_cyc = 1; end
      @(negedge i_clk);
      if (c == 2) chk("mid_busy", {31'b0, o_wb_cyc}, 1);
      if (c == 3) begin
        chk("mid_rst_cyc", {31'b0, o_wb_cyc}, 0);
        chk("mid_rst_acks", {28'b0, o_ibus_ack, o_dbus_ack, o_ext_ack, o_ext_err}, 0);
      end
      if (c == 4) begin
        chk("mid_rst_regrant_adr", o_wb_adr, 32'he000_0000);
        chk("mid_rst_regrant_cyc", {31'b0, o_wb_cyc}, 1);
      end
    end

    // randomized traffic
    rst_dut();
    slave_rand = 1;
    seen = '{0, 0, 0};
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      i_rst = ($urandom_range(0, 399) == 0);
      if (i_ibus_cyc && (seen[0] || $urandom_range(0, 29) == 0)) i_ibus_cyc = 0;
      else if (!i_ibus_cyc && $urandom_range(0, 2) == 0) begin
        i_ibus_cyc = 1; i_ibus_adr = $urandom;
      end
      if (i_dbus_cyc && (seen[1] || $urandom_range(0, 29) == 0)) i_dbus_cyc = 0;
      else if (!i_dbus_cyc && $urandom_range(0, 2) == 0) begin
        i_dbus_cyc = 1; i_dbus_adr = $urandom; i_dbus_dat = $urandom;
        i_dbus_sel = 4'($urandom); i_dbus_we = 1'($urandom);
      end
      if (i_ext_cyc && (seen[2] || $urandom_range(0, 29) == 0)) i_ext_cyc = 0;
      else if (!i_ext_cyc && $urandom_range(0, 2) == 0) begin
        i_ext_cyc = 1; i_ext_adr = $urandom; i_ext_dat = $urandom;
        i_ext_sel = 4'($urandom); i_ext_we = 1'($urandom);
      end
      @(negedge i_clk);
      seen[0] = o_ibus_ack;
      seen[1] = o_dbus_ack;
      seen[2] = o_ext_ack | o_ext_err;
    end
    i_rst = 0;
    idle_masters();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
